cdc_fifo_write_arbiter: RTL

//   Shares the single write port of the cdc_fifo among NUM_REQUESTERS producers in the write clock domain.

---
 rtl/cdc_fifo_write_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing the cdc_fifo write port among NUM_REQUESTERS producers, bursts of up to MAX_BURST beats.
// Latency: grant registered one cycle after valid is seen in IDLE; one IDLE bubble after every release.
// Backpressure: FIFO full stalls the owner (req_ready=0, no write); non-owners are never readied.
module cdc_fifo_write_arbiter #(
    parameter  int NUM_REQUESTERS = 4,
    parameter  int DATA_WIDTH     = 4,
    parameter  int MAX_BURST      = 4,
    localparam int IW             = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
    localparam int BW             = $clog2(MAX_BURST + 1)
) (
    input  logic                                 write_clock,
    input  logic                                 write_reset,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    input  logic                                 full,
    output logic [DATA_WIDTH-1:0]                write_data,
    output logic                                 write_increment,
    output logic [NUM_REQUESTERS-1:0]            grant,
    output logic [IW-1:0]                        grant_index,
    output logic                                 busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   beat_count;
    logic [IW-1:0]   last_owner;
    logic            sel_vld;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   idx;
    logic            owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic            in_grant;
    logic            xfer;
    logic            last_beat;
    logic            release_now;

    // Scan downward so the candidate closest after last_owner is assigned last and wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            idx = IW'((int'(last_owner) + k) % NUM_REQUESTERS);
            if (req_valid[idx]) begin
                sel_vld = 1'b1;
                sel_idx = idx;
            end
        end
    end

    assign owner_valid = req_valid[grant_index];
    assign owner_data  = req_data[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_nxt       = state;
        in_grant        = (state == GRANT);
        xfer            = in_grant & owner_valid & ~full & ~write_reset;
        last_beat       = (beat_count == BW'(MAX_BURST - 1));
        release_now     = in_grant & ((xfer & last_beat) | ~owner_valid);
        req_ready       = '0;
        write_increment = xfer;
        write_data      = '0;
        busy            = in_grant;
        if (in_grant & ~full & ~write_reset) begin
            req_ready = grant;
        end
        if (xfer) begin
            write_data = owner_data;
        end
        case (state)
            IDLE:    if (sel_vld)     state_nxt = GRANT;
            GRANT:   if (release_now) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge write_clock) begin
        if (write_reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_index <= '0;
            beat_count  <= '0;
            last_owner  <= IW'(NUM_REQUESTERS - 1);
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grant       <= {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << sel_idx;
                        grant_index <= sel_idx;
                        beat_count  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last_owner  <= grant_index;
                        grant       <= '0;
                        grant_index <= '0;
                        beat_count  <= '0;
                    end else if (xfer) begin
                        beat_count  <= beat_count + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
